// File: rtl/cache_arbiter.sv
// Two-port arbiter in front of the single-ported cache: picks one requester per transaction,
// drives the one-shot req_do handshake and routes completion and read data back to the owner.
module cache_arbiter #(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p0_data,
  input  logic [31:0] p1_data,
  input  logic [1:0]  p0_type,
  input  logic [1:0]  p1_type,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_done,
  output logic        p1_done,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic [31:0] c_req_addr,
  output logic [31:0] c_req_data,
  output logic [1:0]  c_req_type,
  output logic        c_req_do,
  input  logic [31:0] c_O_data,
  input  logic        c_req_done,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [31:0] c_req_addr_q, c_req_addr_d;
  logic [31:0] c_req_data_q, c_req_data_d;
  logic [1:0]  c_req_type_q, c_req_type_d;
  logic        c_req_do_q, c_req_do_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        win;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    c_req_addr_d = c_req_addr_q;
    c_req_data_d = c_req_data_q;
    c_req_type_d = c_req_type_q;
    c_req_do_d   = 1'b0;
    gnt_d        = 2'b00;
    done_d       = 2'b00;
    rdata_d      = rdata_q;
    busy_d       = busy_q;
    win          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (p0_req || p1_req) begin
          if (p0_req && p1_req) begin
            win = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_owner_q;
          end else begin
            win = p1_req;
          end
          owner_d      = win;
          c_req_addr_d = win ? p1_addr : p0_addr;
          c_req_data_d = win ? p1_data : p0_data;
          c_req_type_d = win ? p1_type : p0_type;
          // Grant and req_do are registered so they appear together in the ISSUE cycle.
          c_req_do_d   = 1'b1;
          gnt_d[win]   = 1'b1;
          busy_d       = 1'b1;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        last_owner_d = owner_q;
        state_d      = StWait;
      end
      StWait: begin
        if (c_req_done) begin
          rdata_d         = c_O_data;
          done_d[owner_q] = 1'b1;
          state_d         = StResp;
        end
      end
      StResp: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      c_req_addr_q <= '0;
      c_req_data_q <= '0;
      c_req_type_q <= '0;
      c_req_do_q   <= 1'b0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      c_req_addr_q <= c_req_addr_d;
      c_req_data_q <= c_req_data_d;
      c_req_type_q <= c_req_type_d;
      c_req_do_q   <= c_req_do_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign p0_gnt     = gnt_q[0];
  assign p1_gnt     = gnt_q[1];
  assign p0_done    = done_q[0];
  assign p1_done    = done_q[1];
  // Read data is only presented to the owner, and only during its done pulse.
  assign p0_rdata   = done_q[0] ? rdata_q : 32'h0;
  assign p1_rdata   = done_q[1] ? rdata_q : 32'h0;
  assign c_req_addr = c_req_addr_q;
  assign c_req_data = c_req_data_q;
  assign c_req_type = c_req_type_q;
  assign c_req_do   = c_req_do_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: instance 0 round-robin, instance 1 fixed priority, each
// with a small behavioural cache (read hit 1, miss 4, write/flush 2, reserved 0 wait cycles).
module tb_cache_arbiter;

  localparam logic [1:0] TyRd = 2'b00;
  localparam logic [1:0] TyWr = 2'b01;
  localparam logic [1:0] TyFl = 2'b10;
  localparam logic [1:0] TyRs = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        req   [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [1:0]  typ   [2][2];
  logic        gnt   [2][2];
  logic        done  [2][2];
  logic [31:0] rdata [2][2];
  logic [31:0] c_addr [2];
  logic [31:0] c_data [2];
  logic [1:0]  c_type [2];
  logic        c_do   [2];
  logic        busy   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 2; k++) begin : g_inst
    logic        c_done_k;
    logic [31:0] c_odata_k;
    logic [31:0] mem [16];
    logic [15:0] vld;
    logic        cbusy;
    int          wt;
    logic [31:0] ca, cd;
    logic [1:0]  ct;

    cache_arbiter #(.FIXED_PRIORITY(k)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .p0_req     (req[k][0]),
      .p1_req     (req[k][1]),
      .p0_addr    (addr[k][0]),
      .p1_addr    (addr[k][1]),
      .p0_data    (wdata[k][0]),
      .p1_data    (wdata[k][1]),
      .p0_type    (typ[k][0]),
      .p1_type    (typ[k][1]),
      .p0_gnt     (gnt[k][0]),
      .p1_gnt     (gnt[k][1]),
      .p0_done    (done[k][0]),
      .p1_done    (done[k][1]),
      .p0_rdata   (rdata[k][0]),
      .p1_rdata   (rdata[k][1]),
      .c_req_addr (c_addr[k]),
      .c_req_data (c_data[k]),
      .c_req_type (c_type[k]),
      .c_req_do   (c_do[k]),
      .c_O_data   (c_odata_k),
      .c_req_done (c_done_k),
      .busy       (busy[k])
    );

    always @(posedge clk) begin
      c_done_k  <= 1'b0;
      c_odata_k <= '0;
      if (reset) begin
        cbusy <= 1'b0;
        vld   <= '0;
        wt    <= 0;
      end else if (c_do[k]) begin
        cbusy <= 1'b1;
        ca    <= c_addr[k];
        cd    <= c_data[k];
        ct    <= c_type[k];
        wt    <= (c_type[k] == TyRd) ? (vld[c_addr[k][5:2]] ? 1 : 4) :
                 (c_type[k] == TyRs) ? 0 : 2;
      end else if (cbusy) begin
        if (wt == 0) begin
          cbusy    <= 1'b0;
          c_done_k <= 1'b1;
          case (ct)
            TyRd: begin
              if (vld[ca[5:2]]) begin
                c_odata_k <= mem[ca[5:2]];
              end else begin
                c_odata_k    <= 32'hDEADBEEF + ca - 32'h100;
                mem[ca[5:2]] <= 32'hDEADBEEF + ca - 32'h100;
                vld[ca[5:2]] <= 1'b1;
              end
            end
            TyWr: begin
              mem[ca[5:2]] <= cd;
              vld[ca[5:2]] <= 1'b1;
            end
            TyFl: vld[ca[5:2]] <= 1'b0;
            default: ;
          endcase
        end else begin
          wt <= wt - 1;
        end
      end
    end
  end

  // Event log of the instance under observation.
  int mon_k = 0;
  int glog[$];
  int dcnt[2] = '{0, 0};
  int docnt = 0;
  int doerr = 0;
  logic prev_do = 1'b0;

  always @(negedge clk) begin
    if (gnt[mon_k][0]) glog.push_back(0);
    if (gnt[mon_k][1]) glog.push_back(1);
    if (done[mon_k][0]) dcnt[0]++;
    if (done[mon_k][1]) dcnt[1]++;
    if (c_do[mon_k]) begin
      docnt++;
      if (prev_do) doerr++;
    end
    prev_do = c_do[mon_k];
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic xact(input int k, input int p, input logic [1:0] ty, input logic [31:0] a,
                      input logic [31:0] d, output int t0, output int tg, output int td,
                      output logic [31:0] rd, output logic [1:0] ctype, output int other);
    other = 0;
    rd    = '0;
    ctype = '0;
    @(posedge clk); #1;
    req[k][p] = 1'b1; addr[k][p] = a; wdata[k][p] = d; typ[k][p] = ty;
    t0 = cyc;
    tg = -1;
    for (int i = 0; i < 40 && tg < 0; i++) begin
      @(negedge clk);
      if (gnt[k][p]) begin
        tg    = cyc;
        ctype = c_type[k];
      end
    end
    @(posedge clk); #1;
    req[k][p] = 1'b0;
    td = -1;
    for (int i = 0; i < 60 && td < 0; i++) begin
      @(negedge clk);
      if (gnt[k][1-p] || done[k][1-p] || rdata[k][1-p] != 32'h0) other++;
      if (done[k][p]) begin
        td = cyc;
        rd = rdata[k][p];
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (busy[k] !== 1'b0 || c_do[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy_do inst %0d got busy=%b do=%b want 0 0", k, busy[k], c_do[k]);
      end
      checks++;
      if (c_addr[k] !== 32'h0 || c_data[k] !== 32'h0 || c_type[k] !== 2'b00) begin
        errors++;
        $display("FAIL reset_creq inst %0d got %h %h %b want 0", k, c_addr[k], c_data[k],
                 c_type[k]);
      end
      checks++;
      if (gnt[k][0] || gnt[k][1] || done[k][0] || done[k][1] || rdata[k][0] !== 32'h0 ||
          rdata[k][1] !== 32'h0) begin
        errors++;
        $display("FAIL reset_ports inst %0d got nonzero gnt/done/rdata want 0", k);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_read_miss();
    int t0, tg, td, other;
    logic [31:0] rd;
    logic [1:0] ct;
    xact(0, 0, TyRd, 32'h100, 32'h0, t0, tg, td, rd, ct, other);
    checks++;
    if (tg != t0 + 1) begin
      errors++; $display("FAIL miss_gnt_latency got %0d want 1", tg - t0);
    end
    checks++;
    if (ct !== TyRd) begin
      errors++; $display("FAIL miss_type got %b want 00", ct);
    end
    checks++;
    if (td != tg + 7) begin
      errors++; $display("FAIL miss_done_latency got %0d want 7", td - tg);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL miss_rdata got %h want deadbeef", rd);
    end
    checks++;
    if (other != 0) begin
      errors++; $display("FAIL miss_other_port got %0d events want 0", other);
    end
  endtask

  task automatic test_write_then_hit();
    int t0, tg, td, other;
    logic [31:0] rd;
    logic [1:0] ct;
    xact(0, 1, TyWr, 32'h104, 32'h12345678, t0, tg, td, rd, ct, other);
    checks++;
    if (tg != t0 + 1 || td != tg + 5 || ct !== TyWr) begin
      errors++;
      $display("FAIL write_timing got gnt+%0d done+%0d type %b want 1 5 01", tg - t0, td - tg, ct);
    end
    xact(0, 1, TyRd, 32'h104, 32'h0, t0, tg, td, rd, ct, other);
    checks++;
    if (td != t0 + 5) begin
      errors++; $display("FAIL hit_done_latency got %0d want 5", td - t0);
    end
    checks++;
    if (rd !== 32'h12345678 || other != 0) begin
      errors++; $display("FAIL hit_rdata got %h other %0d want 12345678 0", rd, other);
    end
  endtask

  task automatic test_round_robin();
    int g0, d0, d1, c0, e0, n;
    mon_k = 0;
    @(posedge clk); #1;
    g0 = glog.size(); d0 = dcnt[0]; d1 = dcnt[1]; c0 = docnt; e0 = doerr;
    req[0][0] = 1'b1; addr[0][0] = 32'h100; typ[0][0] = TyRd;
    req[0][1] = 1'b1; addr[0][1] = 32'h104; typ[0][1] = TyRd;
    for (int i = 0; i < 200 && glog.size() < g0 + 4; i++) @(negedge clk);
    @(posedge clk); #1;
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy[0]) break;
    end
    n = glog.size() - g0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL rr_grant_count got %0d want 4", n);
    end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (glog[g0 + i] != i % 2) begin
        errors++; $display("FAIL rr_order grant %0d got port %0d want %0d", i, glog[g0 + i], i % 2);
      end
    end
    checks++;
    if (dcnt[0] - d0 != 2 || dcnt[1] - d1 != 2) begin
      errors++;
      $display("FAIL rr_done_count got %0d %0d want 2 2", dcnt[0] - d0, dcnt[1] - d1);
    end
    checks++;
    if (docnt - c0 != 4 || doerr != e0) begin
      errors++;
      $display("FAIL rr_req_do got %0d pulses %0d wide want 4 0", docnt - c0, doerr - e0);
    end
  endtask

  task automatic test_fixed_priority();
    int g0, d0, d1, n;
    @(posedge clk); #1;
    mon_k = 1;
    @(negedge clk);
    g0 = glog.size(); d0 = dcnt[0]; d1 = dcnt[1];
    @(posedge clk); #1;
    req[1][0] = 1'b1; addr[1][0] = 32'h100; typ[1][0] = TyRd;
    req[1][1] = 1'b1; addr[1][1] = 32'h104; typ[1][1] = TyRd;
    for (int i = 0; i < 300 && glog.size() < g0 + 3; i++) @(negedge clk);
    @(posedge clk); #1;
    req[1][0] = 1'b0;
    for (int i = 0; i < 100 && glog.size() < g0 + 4; i++) @(negedge clk);
    @(posedge clk); #1;
    req[1][1] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy[1]) break;
    end
    n = glog.size() - g0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL fp_grant_count got %0d want 4", n);
    end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (glog[g0 + i] != ((i == 3) ? 1 : 0)) begin
        errors++;
        $display("FAIL fp_order grant %0d got port %0d want %0d", i, glog[g0 + i], (i == 3) ? 1 : 0);
      end
    end
    checks++;
    if (dcnt[0] - d0 != 3 || dcnt[1] - d1 != 1) begin
      errors++;
      $display("FAIL fp_done_count got %0d %0d want 3 1", dcnt[0] - d0, dcnt[1] - d1);
    end
    mon_k = 0;
  endtask

  task automatic test_reset_mid();
    int t0, tg, td, other, g;
    int d0, d1;
    logic [31:0] rd;
    logic [1:0] ct;
    @(posedge clk); #1;
    req[0][0] = 1'b1; addr[0][0] = 32'h140; typ[0][0] = TyRd;
    g = 0;
    for (int i = 0; i < 20 && g == 0; i++) begin
      @(negedge clk);
      if (gnt[0][0]) g = 1;
    end
    @(posedge clk); #1;
    req[0][0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    d0 = dcnt[0]; d1 = dcnt[1];
    checks++;
    if (busy[0] !== 1'b0 || c_do[0] !== 1'b0 || c_addr[0] !== 32'h0 || done[0][0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state got busy=%b do=%b addr=%h done=%b want 0 0 0 0",
               busy[0], c_do[0], c_addr[0], done[0][0]);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (dcnt[0] != d0 || dcnt[1] != d1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_done got %0d done pulses busy=%b want 0 0",
               dcnt[0] - d0 + dcnt[1] - d1, busy[0]);
    end
    xact(0, 1, TyRd, 32'h100, 32'h0, t0, tg, td, rd, ct, other);
    checks++;
    if (tg != t0 + 1 || td != tg + 7 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rst_mid_after got gnt+%0d done+%0d rdata %h want 1 7 deadbeef",
               tg - t0, td - tg, rd);
    end
  endtask

  task automatic test_flush();
    int t0, tg, td, other;
    logic [31:0] rd;
    logic [1:0] ct;
    xact(0, 0, TyWr, 32'h108, 32'hA5A5A5A5, t0, tg, td, rd, ct, other);
    xact(0, 0, TyFl, 32'h108, 32'h0, t0, tg, td, rd, ct, other);
    checks++;
    if (ct !== TyFl || td != tg + 5) begin
      errors++; $display("FAIL flush_fwd got type %b done+%0d want 10 5", ct, td - tg);
    end
    checks++;
    if (rd !== 32'h0 || other != 0) begin
      errors++; $display("FAIL flush_rdata got %h other %0d want 0 0", rd, other);
    end
    xact(0, 0, TyRd, 32'h108, 32'h0, t0, tg, td, rd, ct, other);
    checks++;
    if (td != tg + 7 || rd !== 32'hDEADBEF7) begin
      errors++; $display("FAIL flush_then_read got done+%0d %h want 7 deadbef7", td - tg, rd);
    end
    xact(0, 1, TyRs, 32'h10C, 32'h0, t0, tg, td, rd, ct, other);
    checks++;
    if (ct !== TyRs || td != tg + 3) begin
      errors++; $display("FAIL reserved_fwd got type %b done+%0d want 11 3", ct, td - tg);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 1'b0; addr[k][p] = '0; wdata[k][p] = '0; typ[k][p] = '0;
      end
    end
    test_reset();
    test_read_miss();
    test_write_then_hit();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid();
    test_flush();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
